// File: rtl/goldilocks_mulmod_pipe.sv
// Multi-lane pipelined MUL/ADD/SUB/SQR modulo the Solinas prime p = 2^(2W) - 2^W + 1.
// Defining MODMUL_TAG_EN adds in_tag/out_tag sideband ports that travel with each beat.
module goldilocks_mulmod_pipe #(
  parameter int unsigned W_WIDTH    = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned PIPE_EXTRA = 0,
  parameter int unsigned TAG_WIDTH  = 8,
  localparam int unsigned P_WIDTH   = 2 * W_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [LANES*P_WIDTH-1:0] in_a,
  input  logic [LANES*P_WIDTH-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*P_WIDTH-1:0] out_data
`ifdef MODMUL_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic [TAG_WIDTH-1:0]     out_tag
`endif
);
  localparam int unsigned WW = W_WIDTH;
  localparam int unsigned PW = P_WIDTH;
  localparam int unsigned XW = 2 * PW;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SQR = 2'b11;
  localparam logic [PW-1:0] P_MOD   = {{WW{1'b1}}, WW'(1)};
  localparam logic [PW:0]   P_MOD_X = {1'b0, P_MOD};

  typedef logic [LANES-1:0][PW-1:0] elem_vec_t;

  if (PIPE_EXTRA > 2 || TAG_WIDTH == 0) begin : g_param_check
    $error("goldilocks_mulmod_pipe: PIPE_EXTRA must be 0..2 and TAG_WIDTH nonzero");
  end

  // Global stall: every stage moves together when the output slot is free.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                          s0_vld_q, s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
  logic [1:0]                    s0_op_q, s1_op_q, s2_op_q, s3_op_q;
  elem_vec_t                     s0_a_q, s0_b_q;
  logic [LANES-1:0][XW-1:0]      s1_x_q, s1_x_d;
  elem_vec_t                     s1_as_q, s1_as_d, s2_as_q, s3_as_q;
  logic [LANES-1:0][PW-1:0]      s2_t_q, s2_t_d;
  logic [LANES-1:0]              s2_brw_q, s2_brw_d;
  logic [LANES-1:0][WW-1:0]      s2_d_q, s2_d_d;
  logic [LANES-1:0][PW:0]        s3_u_q, s3_u_d;
  elem_vec_t                     s4_res_q, s4_res_d;
`ifdef MODMUL_TAG_EN
  logic [TAG_WIDTH-1:0]          s0_tag_q, s1_tag_q, s2_tag_q, s3_tag_q, s4_tag_q;
`endif

  // S1: full product, plus the complete ADD/SUB result which is then padded to S4.
  always_comb begin
    logic [PW-1:0] mb;
    logic [PW:0]   sum;
    logic [PW:0]   dif;
    mb      = '0;
    sum     = '0;
    dif     = '0;
    s1_x_d  = '0;
    s1_as_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      mb        = (s0_op_q == OP_SQR) ? s0_a_q[l] : s0_b_q[l];
      s1_x_d[l] = XW'(s0_a_q[l]) * XW'(mb);
      sum       = {1'b0, s0_a_q[l]} + {1'b0, s0_b_q[l]};
      dif       = {1'b0, s0_a_q[l]} - {1'b0, s0_b_q[l]};
      case (s0_op_q)
        OP_ADD:  s1_as_d[l] = (sum >= P_MOD_X) ? PW'(sum - P_MOD_X) : sum[PW-1:0];
        OP_SUB:  s1_as_d[l] = dif[PW] ? dif[PW-1:0] + P_MOD : dif[PW-1:0];
        default: s1_as_d[l] = '0;
      endcase
    end
  end

  // S2: X = a*2^3W + b*2^2W + c*2^W + d  ->  T = 2^W*(b+c) - (a+b), carry of b+c folded as 2^W-1.
  always_comb begin
    logic [WW-1:0] xa;
    logic [WW-1:0] xb;
    logic [WW-1:0] xc;
    logic [WW:0]   bc;
    logic [WW:0]   ab;
    logic [PW-1:0] hi;
    logic [PW:0]   t;
    xa       = '0;
    xb       = '0;
    xc       = '0;
    bc       = '0;
    ab       = '0;
    hi       = '0;
    t        = '0;
    s2_t_d   = '0;
    s2_brw_d = '0;
    s2_d_d   = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      {xa, xb, xc, s2_d_d[l]} = s1_x_q[l];
      bc          = {1'b0, xb} + {1'b0, xc};
      ab          = {1'b0, xa} + {1'b0, xb};
      hi          = {bc[WW-1:0], {WW{bc[WW]}}};
      t           = {1'b0, hi} - (PW+1)'(ab);
      s2_t_d[l]   = t[PW-1:0];
      s2_brw_d[l] = t[PW];
    end
  end

  // S3: undo a negative T by adding p, then add d keeping the carry.
  always_comb begin
    logic [PW-1:0] v;
    v      = '0;
    s3_u_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      v         = s2_brw_q[l] ? s2_t_q[l] + P_MOD : s2_t_q[l];
      s3_u_d[l] = {1'b0, v} + (PW+1)'(s2_d_q[l]);
    end
  end

  // S4: the sum is below 2p, so one conditional subtract yields the canonical residue.
  always_comb begin
    logic [PW-1:0] red;
    red      = '0;
    s4_res_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      red         = (s3_u_q[l] >= P_MOD_X) ? PW'(s3_u_q[l] - P_MOD_X) : s3_u_q[l][PW-1:0];
      s4_res_d[l] = (s3_op_q == OP_MUL || s3_op_q == OP_SQR) ? red : s3_as_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld_q <= 1'b0;  s1_vld_q <= 1'b0;  s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;  s4_vld_q <= 1'b0;
      s0_op_q  <= '0;    s1_op_q  <= '0;    s2_op_q  <= '0;    s3_op_q <= '0;
      s0_a_q   <= '0;    s0_b_q   <= '0;
      s1_x_q   <= '0;    s1_as_q  <= '0;
      s2_t_q   <= '0;    s2_brw_q <= '0;    s2_d_q   <= '0;    s2_as_q <= '0;
      s3_u_q   <= '0;    s3_as_q  <= '0;
      s4_res_q <= '0;
`ifdef MODMUL_TAG_EN
      s0_tag_q <= '0;    s1_tag_q <= '0;    s2_tag_q <= '0;
      s3_tag_q <= '0;    s4_tag_q <= '0;
`endif
    end else if (advance) begin
      s0_vld_q <= in_valid;   s0_op_q  <= in_op;    s0_a_q  <= in_a;     s0_b_q <= in_b;
      s1_vld_q <= s0_vld_q;   s1_op_q  <= s0_op_q;  s1_x_q  <= s1_x_d;   s1_as_q <= s1_as_d;
      s2_vld_q <= s1_vld_q;   s2_op_q  <= s1_op_q;  s2_t_q  <= s2_t_d;   s2_brw_q <= s2_brw_d;
      s2_d_q   <= s2_d_d;     s2_as_q  <= s1_as_q;
      s3_vld_q <= s2_vld_q;   s3_op_q  <= s2_op_q;  s3_u_q  <= s3_u_d;   s3_as_q <= s2_as_q;
      s4_vld_q <= s3_vld_q;   s4_res_q <= s4_res_d;
`ifdef MODMUL_TAG_EN
      s0_tag_q <= in_tag;     s1_tag_q <= s0_tag_q; s2_tag_q <= s1_tag_q;
      s3_tag_q <= s2_tag_q;   s4_tag_q <= s3_tag_q;
`endif
    end
  end

  if (PIPE_EXTRA == 0) begin : g_out_direct
    assign out_valid = s4_vld_q;
    assign out_data  = s4_res_q;
`ifdef MODMUL_TAG_EN
    assign out_tag   = s4_tag_q;
`endif
  end else begin : g_out_extra
    logic [PIPE_EXTRA-1:0]                  ex_vld_q;
    logic [PIPE_EXTRA-1:0][LANES*PW-1:0]    ex_data_q;
`ifdef MODMUL_TAG_EN
    logic [PIPE_EXTRA-1:0][TAG_WIDTH-1:0]   ex_tag_q;
`endif
    // Extra retiming ranks behind S4, stalled with the rest of the pipe.
    always_ff @(posedge clk) begin
      if (rst) begin
        ex_vld_q  <= '0;
        ex_data_q <= '0;
`ifdef MODMUL_TAG_EN
        ex_tag_q  <= '0;
`endif
      end else if (advance) begin
        ex_vld_q[0]  <= s4_vld_q;
        ex_data_q[0] <= s4_res_q;
`ifdef MODMUL_TAG_EN
        ex_tag_q[0]  <= s4_tag_q;
`endif
        for (int i = 1; i < int'(PIPE_EXTRA); i++) begin
          ex_vld_q[i]  <= ex_vld_q[i-1];
          ex_data_q[i] <= ex_data_q[i-1];
`ifdef MODMUL_TAG_EN
          ex_tag_q[i]  <= ex_tag_q[i-1];
`endif
        end
      end
    end
    assign out_valid = ex_vld_q[PIPE_EXTRA-1];
    assign out_data  = ex_data_q[PIPE_EXTRA-1];
`ifdef MODMUL_TAG_EN
    assign out_tag   = ex_tag_q[PIPE_EXTRA-1];
`endif
  end

endmodule

// File: tb/tb_goldilocks_mulmod_pipe.sv
// Bench for goldilocks_mulmod_pipe: scoreboard against a % based model, PIPE_EXTRA 0 and 2 instances.
module tb_goldilocks_mulmod_pipe;
  localparam int unsigned LANES = 4;
  localparam int unsigned PW    = 64;
  localparam int unsigned DW    = LANES * PW;
  localparam logic [63:0] P     = 64'hFFFF_FFFF_0000_0001;
  localparam logic [63:0] PM1   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [1:0] OP_MUL = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_SQR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid0, in_ready0, out_valid0, out_ready0;
  logic [1:0]    in_op0;
  logic [DW-1:0] in_a0, in_b0, out_data0;
  logic          in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]    in_op2;
  logic [DW-1:0] in_a2, in_b2, out_data2;
`ifdef MODMUL_TAG_EN
  logic [7:0]    in_tag0, out_tag0, in_tag2, out_tag2;
`endif

  goldilocks_mulmod_pipe #(.W_WIDTH(32), .LANES(LANES), .PIPE_EXTRA(0), .TAG_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_op(in_op0),
    .in_a(in_a0), .in_b(in_b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0)
`ifdef MODMUL_TAG_EN
    , .in_tag(in_tag0), .out_tag(out_tag0)
`endif
  );

  goldilocks_mulmod_pipe #(.W_WIDTH(32), .LANES(LANES), .PIPE_EXTRA(2), .TAG_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op2),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2)
`ifdef MODMUL_TAG_EN
    , .in_tag(in_tag2), .out_tag(out_tag2)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb2[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_out0 = 0;
  int   n_out2 = 0;
  bit   lat_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_lane(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] r;
    case (op)
      OP_MUL:  r = 128'(a) * 128'(b);
      OP_ADD:  r = 128'(a) + 128'(b);
      OP_SUB:  r = 128'(a) + 128'(P) - 128'(b);
      default: r = 128'(a) * 128'(a);
    endcase
    return 64'(r % 128'(P));
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < int'(LANES); l++)
      r[l*PW +: PW] = ref_lane(op, a[l*PW +: PW], b[l*PW +: PW]);
    return r;
  endfunction

  function automatic logic [63:0] rnd_elem();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0:       r = 64'd0;
      1:       r = PM1;
      default: r = {$urandom, $urandom} % P;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < int'(LANES); l++) r[l*PW +: PW] = rnd_elem();
    return r;
  endfunction

  // Scoreboards: pop on a transfer about to happen, push on an accept about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid0 && out_ready0) begin
      chk("d0_unexpected_out", DW'(sb0.size() != 0), DW'(1));
      if (sb0.size() != 0) begin
        e = sb0.pop_front();
        n_out0++;
        chk("d0_data", out_data0, e.data);
        if (e.lat) chk("d0_latency", DW'(cyc - e.cyc - 1), DW'(4));
        for (int l = 0; l < int'(LANES); l++)
          chk("d0_lt_p", DW'(out_data0[l*PW +: PW] < P), DW'(1));
      end
    end
    if (!rst && in_valid0 && in_ready0) begin
      e.data = ref_beat(in_op0, in_a0, in_b0);
      e.cyc  = cyc;
      e.lat  = lat_en;
      sb0.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid2 && out_ready2) begin
      chk("d2_unexpected_out", DW'(sb2.size() != 0), DW'(1));
      if (sb2.size() != 0) begin
        e = sb2.pop_front();
        n_out2++;
        chk("d2_data", out_data2, e.data);
        if (e.lat) chk("d2_latency", DW'(cyc - e.cyc - 1), DW'(6));
        for (int l = 0; l < int'(LANES); l++)
          chk("d2_lt_p", DW'(out_data2[l*PW +: PW] < P), DW'(1));
      end
    end
    if (!rst && in_valid2 && in_ready2) begin
      e.data = ref_beat(in_op2, in_a2, in_b2);
      e.cyc  = cyc;
      e.lat  = lat_en;
      sb2.push_back(e);
    end
  end

  task automatic send0(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int g = 0;
    in_valid0 = 1'b1; in_op0 = op; in_a0 = a; in_b0 = b;
    @(negedge clk);
    while (!in_ready0 && g < 50) begin @(negedge clk); g++; end
    chk("d0_send_ready", DW'(in_ready0), DW'(1));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic send2(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int g = 0;
    in_valid2 = 1'b1; in_op2 = op; in_a2 = a; in_b2 = b;
    @(negedge clk);
    while (!in_ready2 && g < 50) begin @(negedge clk); g++; end
    chk("d2_send_ready", DW'(in_ready2), DW'(1));
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic wait_out0(output int k);
    k = 0;
    @(negedge clk);
    while (!out_valid0 && k < 30) begin @(negedge clk); k++; end
  endtask

  task automatic drain(input bit second);
    int g = 0;
    while ((second ? sb2.size() : sb0.size()) != 0 && g < 60) begin @(posedge clk); g++; end
    chk(second ? "d2_drain" : "d0_drain", DW'(second ? sb2.size() : sb0.size()), DW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k, idx, stall_left, g, base;
    bit            stalled, acc;
    logic [DW-1:0] hold;
    logic [1:0]    ops [8];
    logic [DW-1:0] as [8];
    logic [DW-1:0] bs [8];

    in_valid0 = 0; in_op0 = '0; in_a0 = '0; in_b0 = '0; out_ready0 = 1;
    in_valid2 = 0; in_op2 = '0; in_a2 = '0; in_b2 = '0; out_ready2 = 1;
`ifdef MODMUL_TAG_EN
    in_tag0 = '0; in_tag2 = '0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid0", DW'(out_valid0), DW'(0));
    chk("rst_out_data0", out_data0, DW'(0));
    chk("rst_out_valid2", DW'(out_valid2), DW'(0));
    chk("rst_out_data2", out_data2, DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", DW'(in_ready0), DW'(1));
    @(posedge clk); #1;

    // (p-1)^2 = 1 on all lanes, four cycles after accept
    lat_en = 1'b1;
    send0(OP_MUL, {4{PM1}}, {4{PM1}});
    wait_out0(k);
    chk("t1_latency", DW'(k), DW'(4));
    chk("t1_data", out_data0, {4{64'h1}});
    drain(1'b0);

    // Folding boundaries per lane, then a SQR beat whose b is ignored
    send0(OP_MUL, {64'd3, 64'd0, 64'h0001_0000_0000_0000, 64'h1_0000_0000},
                  {64'd3, PM1,   64'h0001_0000_0000_0000, 64'h1_0000_0000});
    send0(OP_SQR, {4{64'd3}}, rnd_beat());
    wait_out0(k);
    chk("t2_wait", DW'(out_valid0), DW'(1));
    chk("t2_mul", out_data0, {64'd9, 64'd0, PM1, 64'h0000_0000_FFFF_FFFF});
    @(negedge clk);
    chk("t2_sqr_valid", DW'(out_valid0), DW'(1));
    chk("t2_sqr", out_data0, {4{64'd9}});
    drain(1'b0);

    // ADD and SUB boundaries back-to-back with MUL/SUB beats
    send0(OP_ADD, {PM1, 64'd0, PM1, PM1}, {PM1, 64'd0, 64'd1, 64'd2});
    send0(OP_SUB, {64'd1, PM1, 64'd5, 64'd0}, {PM1, 64'd0, 64'd5, 64'd1});
    send0(OP_MUL, rnd_beat(), rnd_beat());
    send0(OP_SUB, rnd_beat(), rnd_beat());
    wait_out0(k);
    chk("t3_wait", DW'(out_valid0), DW'(1));
    chk("t3_add", out_data0, {64'hFFFF_FFFE_FFFF_FFFF, 64'd0, 64'd0, 64'd1});
    @(negedge clk);
    chk("t3_sub", out_data0, {64'd2, PM1, 64'd0, PM1});
    drain(1'b0);

    // Eight-beat stream with a three-cycle stall at the first output
    lat_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ops[i] = 2'($urandom_range(0, 3)); as[i] = rnd_beat(); bs[i] = rnd_beat();
    end
    base = n_out0; idx = 0; stall_left = 0; stalled = 0; g = 0; hold = '0;
    while ((idx < 8 || sb0.size() != 0) && g < 200) begin
      if (idx < 8) begin
        in_valid0 = 1'b1; in_op0 = ops[idx]; in_a0 = as[idx]; in_b0 = bs[idx];
      end else begin
        in_valid0 = 1'b0;
      end
      if (!stalled && out_valid0) begin
        stalled = 1'b1; stall_left = 3; hold = out_data0;
      end
      out_ready0 = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_in_ready", DW'(in_ready0), DW'(0));
        chk("stall_out_valid", DW'(out_valid0), DW'(1));
        chk("stall_out_data", out_data0, hold);
        stall_left--;
      end
      acc = in_valid0 && in_ready0;
      @(posedge clk); #1;
      if (acc) idx++;
      g++;
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    chk("stall_seen", DW'(stalled), DW'(1));
    chk("stall_count", DW'(n_out0 - base), DW'(8));
    chk("stall_drain", DW'(sb0.size()), DW'(0));

    // Reset with three beats in flight discards them all
    send0(OP_MUL, rnd_beat(), rnd_beat());
    send0(OP_ADD, rnd_beat(), rnd_beat());
    send0(OP_SQR, rnd_beat(), rnd_beat());
    rst = 1'b1;
    sb0.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", DW'(out_valid0), DW'(0));
    chk("mid_rst_out_data", out_data0, DW'(0));
    chk("mid_rst_in_ready", DW'(in_ready0), DW'(1));
    base = n_out0; k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid0) k++;
    end
    chk("mid_rst_no_output", DW'(k), DW'(0));
    chk("mid_rst_no_pop", DW'(n_out0 - base), DW'(0));
    @(posedge clk); #1;

    // PIPE_EXTRA=2: random canonical operands, latency 6
    lat_en = 1'b1;
    base = n_out2;
    for (int i = 0; i < 20; i++) send2(2'($urandom_range(0, 3)), rnd_beat(), rnd_beat());
    drain(1'b1);
    chk("d2_count", DW'(n_out2 - base), DW'(20));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
